// File: rtl/xunit_m_pkg.sv
// Shared constants, phase encoding and rotate helper for the SHA-256
// message-schedule expansion unit (xunit_m).
package xunit_m_pkg;

    localparam int DATA_W = 32;
    localparam int NWORDS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        LOAD    = 2'd2,
        COMPUTE = 2'd3
    } phase_e;

    // small sigma rotation/shift amounts
    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

endpackage

// File: rtl/xunit_m_if.sv
// Data-side bundle of xunit_m: run pulse, message word in, delay, schedule
// word out. Optional `done` pulse exists only when XUNITM_DONE_EN is defined.
interface xunit_m_if
    import xunit_m_pkg::*;
#(
    parameter int DELAY_W = 8
);
    logic               run;
    logic [DATA_W-1:0]  in0;
    logic [DELAY_W-1:0] delay0;
    logic [DATA_W-1:0]  out0;
`ifdef XUNITM_DONE_EN
    logic               done;

    modport master (output run, in0, delay0, input out0, done);
    modport slave  (input run, in0, delay0, output out0, done);
`else
    modport master (output run, in0, delay0, input out0);
    modport slave  (input run, in0, delay0, output out0);
`endif
endinterface

// File: rtl/xunit_m_sha256_sigma.sv
// Combinational SHA-256 small sigma: sel=0 gives sigma0, sel=1 gives sigma1.
module sha256_sigma
    import xunit_m_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);
    logic [DATA_W-1:0] sig0, sig1;

    assign sig0 = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
    assign sig1 = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
    assign y    = sel ? sig1 : sig0;
endmodule

// File: rtl/xunit_m.sv
// SHA-256 message-schedule expansion: after `run` and an optional start
// delay, loads W0..W15 and then emits W16..W31, one word per cycle.
// Optional feature macro: XUNITM_DONE_EN (adds a `done` pulse with W31).
module xunit_m
    import xunit_m_pkg::*;
#(
    parameter int DELAY_W = 8
)(
    input  logic      clk,
    input  logic      rst,
    xunit_m_if.slave  bus
);
    localparam int WCNT_W = $clog2(NWORDS);
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(NWORDS - 1);

    phase_e                         state;
    logic [DELAY_W-1:0]             dcnt;
    logic [WCNT_W-1:0]              wcnt;
    logic [NWORDS-1:0][DATA_W-1:0]  win;   // win[0] oldest .. win[NWORDS-1] newest
    logic [DATA_W-1:0]              out_q;
    logic [DATA_W-1:0]              s0, s1, wn;
`ifdef XUNITM_DONE_EN
    logic                           done_q;
    assign bus.done = done_q;
`endif

    sha256_sigma u_sig0 (.x(win[1]),  .sel(1'b0), .y(s0));
    sha256_sigma u_sig1 (.x(win[14]), .sel(1'b1), .y(s1));

    assign wn       = s1 + win[9] + s0 + win[0];
    assign bus.out0 = out_q;

    // Phase sequencer, window shifter and output register; run restarts from any phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            wcnt  <= '0;
            win   <= '0;
            out_q <= '0;
`ifdef XUNITM_DONE_EN
            done_q <= 1'b0;
`endif
        end else begin
`ifdef XUNITM_DONE_EN
            done_q <= 1'b0;
`endif
            if (bus.run) begin
                dcnt  <= bus.delay0;
                wcnt  <= '0;
                state <= (bus.delay0 == '0) ? LOAD : WAIT;
            end else begin
                case (state)
                    IDLE: ;
                    WAIT: begin
                        dcnt <= dcnt - 1'b1;
                        if (dcnt == DELAY_W'(1)) state <= LOAD;
                    end
                    LOAD: begin
                        win  <= {bus.in0, win[NWORDS-1:1]};
                        wcnt <= wcnt + 1'b1;   // wraps to 0 entering COMPUTE
                        if (wcnt == WLAST) state <= COMPUTE;
                    end
                    COMPUTE: begin
                        win   <= {wn, win[NWORDS-1:1]};
                        out_q <= wn;
                        wcnt  <= wcnt + 1'b1;
                        if (wcnt == WLAST) begin
                            state <= IDLE;
`ifdef XUNITM_DONE_EN
                            done_q <= 1'b1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_xunit_m.sv
// Scoreboard bench for xunit_m: stimulus pushes expected (cycle, word) pairs,
// a negedge monitor pops and compares them against out0 (and done if built).
module tb_xunit_m;
    typedef logic [31:0] blk_t [16];
    typedef struct {
        int          due;
        logic [31:0] val;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    exp_t q[$];

    xunit_m_if #(.DELAY_W(8)) bus ();
    xunit_m #(.DELAY_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference schedule, written directly in W[t] index form.
    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction
    function automatic void sched(input blk_t m, output blk_t o);
        logic [31:0] w [32];
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 32; t++) begin
            w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
            o[t-16] = w[t];
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    // Monitor: compares whatever expectation falls due on this cycle.
    always @(negedge clk) begin
        bit expd;
        exp_t e;
        expd = 1'b0;
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_tot++;
            $display("FAIL missed cyc=%0d got=none want=%h", e.due, e.val);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out0", bus.out0, e.val);
            expd = e.last;
        end
`ifdef XUNITM_DONE_EN
        if (cyc >= 1) chk("done", {31'b0, bus.done}, {31'b0, expd});
`endif
    end

    // Issue run, feed nfeed words after the delay, queue npush expected outputs.
    task automatic run_block(input int d, input blk_t blk, input blk_t exp,
                             input int npush, input int nfeed, output int e0);
        bus.run = 1'b1;
        bus.delay0 = 8'(d);
        e0 = cyc + 1;
        for (int k = 0; k < npush; k++)
            q.push_back('{due: e0 + 17 + d + k, val: exp[k], last: (k == 15)});
        @(posedge clk); #1;
        bus.run = 1'b0;
        bus.delay0 = 8'($urandom);
        repeat (d) begin
            bus.in0 = $urandom;
            @(posedge clk); #1;
        end
        for (int i = 0; i < nfeed; i++) begin
            bus.in0 = blk[i];
            @(posedge clk); #1;
        end
        bus.in0 = $urandom;
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() > 0 && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tot++;
            $display("FAIL timeout due=%0d got=none want=%h", e.due, e.val);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    blk_t abc, abc_exp, zero, rnd, rnd_exp;
    int   e0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'h0;
            zero[i] = 32'h0;
            rnd[i]  = $urandom;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        sched(abc, abc_exp);
        abc_exp[0] = 32'h61626380;
        abc_exp[1] = 32'h000F0000;
        abc_exp[2] = 32'h7DA86405;
        sched(rnd, rnd_exp);

        rst = 1'b1;
        bus.run = 1'b0;
        bus.in0 = 32'h0;
        bus.delay0 = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.push_back('{due: cyc, val: 32'h0, last: 1'b0});

        // abc, no delay; then out0 must hold W31 while idle
        run_block(0, abc, abc_exp, 16, 16, e0);
        q.push_back('{due: e0 + 32 + 3, val: abc_exp[15], last: 1'b0});
        drain();

        // all-zero block
        run_block(0, zero, zero, 16, 16, e0);
        drain();

        // abc with a 5-cycle start delay
        run_block(5, abc, abc_exp, 16, 16, e0);
        drain();

        // reset in the middle of COMPUTE, then a clean run
        run_block(0, abc, abc_exp, 5, 16, e0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        q.push_back('{due: cyc + 1, val: 32'h0, last: 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        q.push_back('{due: cyc + 3, val: 32'h0, last: 1'b0});
        drain();
        run_block(0, abc, abc_exp, 16, 16, e0);
        drain();

        // second run during LOAD: only the second block's results appear
        run_block(0, rnd, rnd_exp, 0, 8, e0);
        run_block(3, abc, abc_exp, 16, 16, e0);
        drain();

        // arbitrary block with a 2-cycle delay
        run_block(2, rnd, rnd_exp, 16, 16, e0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
